// File: rtl/ccw_retry_ctrl.sv
// CCW retry/emergency controller: delayed repeat on device busy, immediate
// round-robin source switch on no-reply/error, fail pulse when limits run out.
module ccw_retry_ctrl #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DELAY_MS     = 100,
  parameter int unsigned MAX_BUSY_RPT = 3,
  parameter int unsigned MAX_ERR_RPT  = 2,
  parameter int unsigned N_SRC        = 2,
  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int unsigned BW = (MAX_BUSY_RPT > 0) ? $clog2(MAX_BUSY_RPT + 1) : 1,
  localparam int unsigned EW = (MAX_ERR_RPT > 0) ? $clog2(MAX_ERR_RPT + 1) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          ccw_accepted,
  input  logic          sd_busy,
  input  logic          no_reply_or_err,
  output logic          repeat_req,
  output logic          switch_src_req,
  output logic [SW-1:0] src_sel,
  output logic          fail,
  output logic          delay_active,
  output logic [BW-1:0] busy_cnt,
  output logic [EW-1:0] err_cnt
);

  localparam int unsigned DELAY_TICKS = CLK_FREQ / 1000 * DELAY_MS - 1;
  localparam int unsigned TW = (DELAY_TICKS > 0) ? $clog2(DELAY_TICKS + 1) : 1;

  typedef enum logic {IDLE, DELAY} state_t;

  state_t        state;
  logic [TW-1:0] tick;

  // Event priority: accept beats error, error beats busy; pulses default low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      tick           <= '0;
      repeat_req     <= 1'b0;
      switch_src_req <= 1'b0;
      src_sel        <= '0;
      fail           <= 1'b0;
      delay_active   <= 1'b0;
      busy_cnt       <= '0;
      err_cnt        <= '0;
    end else begin
      repeat_req     <= 1'b0;
      switch_src_req <= 1'b0;
      fail           <= 1'b0;
      if (ccw_accepted) begin
        state        <= IDLE;
        tick         <= '0;
        delay_active <= 1'b0;
        busy_cnt     <= '0;
        err_cnt      <= '0;
      end else if (no_reply_or_err) begin
        state        <= IDLE;
        tick         <= '0;
        delay_active <= 1'b0;
        if (err_cnt < EW'(MAX_ERR_RPT)) begin
          err_cnt        <= err_cnt + EW'(1);
          repeat_req     <= 1'b1;
          switch_src_req <= 1'b1;
          if (src_sel == SW'(N_SRC - 1)) src_sel <= '0;
          else                           src_sel <= src_sel + SW'(1);
        end else begin
          fail     <= 1'b1;
          busy_cnt <= '0;
          err_cnt  <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (sd_busy) begin
              if (busy_cnt < BW'(MAX_BUSY_RPT)) begin
                busy_cnt     <= busy_cnt + BW'(1);
                tick         <= '0;
                state        <= DELAY;
                delay_active <= 1'b1;
              end else begin
                fail     <= 1'b1;
                busy_cnt <= '0;
                err_cnt  <= '0;
              end
            end
          end
          DELAY: begin
            // Further busy replies while waiting are ignored.
            if (tick == TW'(DELAY_TICKS)) begin
              state        <= IDLE;
              tick         <= '0;
              delay_active <= 1'b0;
              repeat_req   <= 1'b1;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          default: begin
            state        <= IDLE;
            tick         <= '0;
            delay_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
